debug_dump_tx: RTL and testbench

Transmit-side engine of the UART debug link. On a start pulse it snapshots the pipeline PC, walks the register file and data memory through their debug read ports, and streams a fixed-format byte frame into the UART TX FIFO. It respects the FIFO-full handshake. It sits beside the RX-side debug command interface, drives `uart_top`'s `i_w_data`/`i_wr_uart`, and observes `o_tx_full`.

---
 rtl/debug_dump_tx.sv | 189 ++++++++++++++++++
 tb/tb_debug_dump_tx.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_dump_tx.sv
// debug_dump_tx
//   Transmit side of the UART debug link. A start pulse snapshots the PC,
//   then the register file and data memory are walked through their debug
//   read ports and streamed as a byte frame into the UART TX FIFO:
//     A5 | PC (LE) | reg 0..2**REG_ADDR-1 (LE) | mem 0..N_MEM-1 (LE) | xor
//   The checksum is the XOR of every byte between header and checksum.
//
// Ports
//   i_clock, i_reset      clock, async active-low reset
//   i_start               dump request, sampled only in IDLE
//   i_fifo_full           TX FIFO full; stalls the byte being offered
//   i_pc                  PC captured at start
//   i_reg_data            register read data, one cycle after o_addr_ID
//   i_mem_data            memory read data, one cycle after o_addr_M/o_mem_r
//   o_addr_ID, o_addr_M   debug read addresses
//   o_mem_r               memory debug read enable
//   o_tx_data, o_wr       byte and write strobe into the TX FIFO
//   o_busy, o_done        frame in progress / one-cycle completion pulse
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | wait for i_start, capture PC
// HDR      | offer header byte 0xA5
// PC_SEND  | offer PC bytes, LSB first
// R_FETCH  | drive register address
// R_LATCH  | capture register word, reload byte counter
// R_SEND   | offer register bytes, LSB first
// M_FETCH  | drive memory address with read enable
// M_LATCH  | capture memory word, reload byte counter
// M_SEND   | offer memory bytes, LSB first
// CKSUM    | offer checksum byte
// DONE     | one-cycle completion pulse

module debug_dump_tx #(
    parameter int DATA_SZ  = 32,
    parameter int PC_SZ    = 32,
    parameter int REG_ADDR = 5,
    parameter int MEM_ADDR = 5,
    parameter int N_MEM    = 32
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_fifo_full,
    input  logic [PC_SZ-1:0]    i_pc,
    input  logic [DATA_SZ-1:0]  i_reg_data,
    input  logic [DATA_SZ-1:0]  i_mem_data,
    output logic [REG_ADDR-1:0] o_addr_ID,
    output logic [MEM_ADDR-1:0] o_addr_M,
    output logic                o_mem_r,
    output logic [7:0]          o_tx_data,
    output logic                o_wr,
    output logic                o_busy,
    output logic                o_done
);

    localparam int PC_BYTES = PC_SZ / 8;
    localparam int W_BYTES  = DATA_SZ / 8;
    localparam int SH_W     = (PC_SZ > DATA_SZ) ? PC_SZ : DATA_SZ;
    localparam int MAX_B    = (PC_BYTES > W_BYTES) ? PC_BYTES : W_BYTES;
    localparam int CNT_W    = $clog2(MAX_B + 1);

    localparam logic [7:0]          HDR_BYTE = 8'hA5;
    localparam logic [REG_ADDR-1:0] REG_LAST = '1;
    localparam logic [MEM_ADDR-1:0] MEM_LAST = MEM_ADDR'(N_MEM - 1);
    localparam logic [CNT_W-1:0]    PC_CNT   = CNT_W'(PC_BYTES - 1);
    localparam logic [CNT_W-1:0]    W_CNT    = CNT_W'(W_BYTES - 1);

    typedef enum logic [3:0] {
        IDLE, HDR, PC_SEND, R_FETCH, R_LATCH, R_SEND,
        M_FETCH, M_LATCH, M_SEND, CKSUM, DONE
    } state_t;

    state_t               state_q, state_d;
    logic [SH_W-1:0]      sh_q, sh_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           cks_q, cks_d;
    logic [REG_ADDR-1:0]  reg_addr_q, reg_addr_d;
    logic [MEM_ADDR-1:0]  mem_addr_q, mem_addr_d;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            cnt_q      <= '0;
            cks_q      <= 8'h00;
            reg_addr_q <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            cks_q      <= cks_d;
            reg_addr_q <= reg_addr_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        cks_d      = cks_q;
        reg_addr_d = reg_addr_q;
        mem_addr_d = mem_addr_q;
        o_wr       = 1'b0;
        o_tx_data  = 8'h00;
        o_mem_r    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    sh_d       = SH_W'(i_pc);
                    cks_d      = 8'h00;
                    cnt_d      = PC_CNT;
                    reg_addr_d = '0;
                    state_d    = HDR;
                end
            end
            HDR: begin
                o_wr      = !i_fifo_full;
                o_tx_data = HDR_BYTE;
                if (!i_fifo_full) state_d = PC_SEND;
            end
            PC_SEND, R_SEND, M_SEND: begin
                o_wr      = !i_fifo_full;
                o_tx_data = sh_q[7:0];
                if (!i_fifo_full) begin
                    sh_d  = sh_q >> 8;
                    cks_d = cks_q ^ sh_q[7:0];
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        // terminal count: word finished, pick the next word
                        case (state_q)
                            PC_SEND: state_d = R_FETCH;
                            R_SEND: begin
                                reg_addr_d = reg_addr_q + REG_ADDR'(1);
                                if (reg_addr_q == REG_LAST) begin
                                    mem_addr_d = '0;
                                    state_d    = M_FETCH;
                                end else begin
                                    state_d = R_FETCH;
                                end
                            end
                            default: begin
                                if (mem_addr_q == MEM_LAST) begin
                                    state_d = CKSUM;
                                end else begin
                                    mem_addr_d = mem_addr_q + MEM_ADDR'(1);
                                    state_d    = M_FETCH;
                                end
                            end
                        endcase
                    end
                end
            end
            R_FETCH: state_d = R_LATCH;
            R_LATCH: begin
                sh_d    = SH_W'(i_reg_data);
                cnt_d   = W_CNT;
                state_d = R_SEND;
            end
            M_FETCH: begin
                o_mem_r = 1'b1;
                state_d = M_LATCH;
            end
            M_LATCH: begin
                o_mem_r = 1'b1;
                sh_d    = SH_W'(i_mem_data);
                cnt_d   = W_CNT;
                state_d = M_SEND;
            end
            CKSUM: begin
                o_wr      = !i_fifo_full;
                o_tx_data = cks_q;
                if (!i_fifo_full) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_addr_ID = reg_addr_q;
    assign o_addr_M  = mem_addr_q;
    assign o_busy    = (state_q != IDLE);
    assign o_done    = (state_q == DONE);

endmodule

// File: tb/tb_debug_dump_tx.sv
module tb_debug_dump_tx;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic        i_fifo_full;
    logic [31:0] i_pc;
    logic [31:0] i_reg_data;
    logic [31:0] i_mem_data;
    logic [4:0]  o_addr_ID;
    logic [4:0]  o_addr_M;
    logic        o_mem_r;
    logic [7:0]  o_tx_data;
    logic        o_wr;
    logic        o_busy;
    logic        o_done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    // monitor state, written only by the monitor process
    logic prev_busy = 1'b0;
    logic [4:0] prev_id = '0;
    logic memr_seen = 1'b0;
    int memr_cnt = 0;
    int addr_m_bad = 0;
    int id_ok = 0;
    int id_bad = 0;

    debug_dump_tx dut (
        .i_clock     (clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_fifo_full (i_fifo_full),
        .i_pc        (i_pc),
        .i_reg_data  (i_reg_data),
        .i_mem_data  (i_mem_data),
        .o_addr_ID   (o_addr_ID),
        .o_addr_M    (o_addr_M),
        .o_mem_r     (o_mem_r),
        .o_tx_data   (o_tx_data),
        .o_wr        (o_wr),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    // register file: reg i = i; memory: word j = 0x100 + j; one-cycle read latency
    always @(posedge clk) begin
        i_reg_data <= {27'd0, o_addr_ID};
        if (o_mem_r) i_mem_data <= 32'h100 + {27'd0, o_addr_M};
    end

    always @(negedge clk) begin
        prev_busy <= o_busy;
        prev_id   <= o_addr_ID;
        if (o_busy && !prev_busy) begin
            memr_cnt   <= 0;
            addr_m_bad <= 0;
            id_ok      <= 0;
            id_bad     <= 0;
            memr_seen  <= 1'b0;
        end else begin
            if (o_mem_r) begin
                memr_cnt  <= memr_cnt + 1;
                memr_seen <= 1'b1;
                if (o_addr_M !== 5'(memr_cnt >> 1)) addr_m_bad <= addr_m_bad + 1;
            end
            if (o_busy && !memr_seen && o_addr_ID !== prev_id) begin
                if (o_addr_ID === prev_id + 5'd1) id_ok <= id_ok + 1;
                else id_bad <= id_bad + 1;
            end
        end
    end

    function automatic void build_exp(input logic [31:0] pc);
        logic [7:0]  cks;
        logic [31:0] w;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        cks = 8'h00;
        for (int b = 0; b < 4; b++) begin
            exp_q.push_back(pc[8*b +: 8]);
            cks ^= pc[8*b +: 8];
        end
        for (int i = 0; i < 64; i++) begin
            w = (i < 32) ? 32'(i) : 32'h100 + 32'(i - 32);
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(w[8*b +: 8]);
                cks ^= w[8*b +: 8];
            end
        end
        exp_q.push_back(cks);
    endfunction

    function automatic int first_diff();
        if (got.size() != exp_q.size()) return -2;
        for (int i = 0; i < got.size(); i++)
            if (got[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    // Issues one start pulse and runs the frame to o_done. A small position
    // model counts the cycles in which a byte was due but the FIFO was full.
    task automatic drive_frame(input logic [31:0] pc, input bit stall, input bit jitter,
                               output int stalls, output int done_at,
                               output int n_wr, output int wr_full);
        int pos;
        int gap;
        got.delete();
        stalls = 0; done_at = -1; n_wr = 0; wr_full = 0;
        pos = 0; gap = 0;
        @(negedge clk);
        i_pc = pc;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        if (jitter) i_pc = $urandom;
        i_fifo_full = stall ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int c = 1; c <= 1500; c++) begin
            @(negedge clk);
            if (o_wr) begin
                got.push_back(o_tx_data);
                n_wr++;
                if (i_fifo_full) wr_full++;
            end
            if (gap > 0) begin
                gap--;
            end else if (pos < 262) begin
                if (i_fifo_full) begin
                    stalls++;
                end else begin
                    pos++;
                    if (pos >= 5 && pos <= 257 && ((pos - 5) % 4) == 0) gap = 2;
                end
            end
            if (o_done) begin
                done_at = c;
                break;
            end
            @(posedge clk);
            #1;
            if (jitter) i_pc = $urandom;
            i_fifo_full = stall ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        i_fifo_full = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (o_wr !== 1'b0) begin tests_failed++; $display("FAIL reset_wr got %b want 0", o_wr); end
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", o_busy); end
        tests_run++; if (o_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", o_done); end
        tests_run++; if (o_mem_r !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_r got %b want 0", o_mem_r); end
        tests_run++; if (o_tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data got %h want 00", o_tx_data); end
        tests_run++; if (o_addr_ID !== 5'd0) begin tests_failed++; $display("FAIL reset_addr_id got %0d want 0", o_addr_ID); end
        tests_run++; if (o_addr_M !== 5'd0) begin tests_failed++; $display("FAIL reset_addr_m got %0d want 0", o_addr_M); end
        i_reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (o_busy !== 1'b0 || o_wr !== 1'b0) begin
            tests_failed++; $display("FAIL idle_after_reset busy %b wr %b want 0 0", o_busy, o_wr);
        end
    endtask

    task automatic test_basic_frame();
        int stalls, done_at, n_wr, wr_full, d;
        build_exp(32'h0000_0040);
        drive_frame(32'h0000_0040, 1'b0, 1'b0, stalls, done_at, n_wr, wr_full);
        tests_run++; if (n_wr != 262) begin tests_failed++; $display("FAIL basic_nbytes got %0d want 262", n_wr); end
        d = first_diff();
        tests_run++; if (d != -1) begin tests_failed++; $display("FAIL basic_bytes first diff at %0d (got size %0d want 262)", d, got.size()); end
        tests_run++;
        if (got.size() != 262 || got[261] !== 8'h40) begin
            tests_failed++; $display("FAIL basic_checksum got %h want 40", (got.size() == 262) ? got[261] : 8'hxx);
        end
        tests_run++; if (done_at != 391) begin tests_failed++; $display("FAIL basic_done_cycle got %0d want 391", done_at); end
        @(negedge clk);
        tests_run++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            tests_failed++; $display("FAIL basic_busy_after_done busy %b done %b want 0 0", o_busy, o_done);
        end
        tests_run++; if (memr_cnt != 64) begin tests_failed++; $display("FAIL mem_r_cycles got %0d want 64", memr_cnt); end
        tests_run++; if (addr_m_bad != 0) begin tests_failed++; $display("FAIL addr_m_order got %0d bad want 0", addr_m_bad); end
        tests_run++;
        if (id_ok != 32 || id_bad != 0) begin
            tests_failed++; $display("FAIL addr_id_order steps %0d bad %0d want 32 0", id_ok, id_bad);
        end
    endtask

    task automatic test_stall();
        int stalls, done_at, n_wr, wr_full, d;
        build_exp(32'h0000_0040);
        drive_frame(32'h0000_0040, 1'b1, 1'b0, stalls, done_at, n_wr, wr_full);
        tests_run++; if (n_wr != 262) begin tests_failed++; $display("FAIL stall_nbytes got %0d want 262", n_wr); end
        d = first_diff();
        tests_run++; if (d != -1) begin tests_failed++; $display("FAIL stall_bytes first diff at %0d", d); end
        tests_run++; if (wr_full != 0) begin tests_failed++; $display("FAIL stall_wr_while_full got %0d want 0", wr_full); end
        tests_run++; if (stalls == 0) begin tests_failed++; $display("FAIL stall_pattern got %0d stalls want >0", stalls); end
        tests_run++;
        if (done_at != 391 + stalls) begin
            tests_failed++; $display("FAIL stall_done_cycle got %0d want %0d", done_at, 391 + stalls);
        end
    endtask

    task automatic test_start_hold();
        int n_wr, n_done, done_c, stalls, done_at, wr_full, d;
        n_wr = 0; n_done = 0; done_c = -1;
        @(negedge clk);
        i_pc = 32'h0000_0040;
        i_start = 1'b1;
        for (int c = 1; c <= 600; c++) begin
            @(posedge clk);
            #1;
            i_start = (c < 10) || (c == 200);
            @(negedge clk);
            if (o_wr) n_wr++;
            if (o_done) begin n_done++; done_c = c; end
        end
        i_start = 1'b0;
        tests_run++; if (n_wr != 262) begin tests_failed++; $display("FAIL hold_nbytes got %0d want 262", n_wr); end
        tests_run++; if (n_done != 1) begin tests_failed++; $display("FAIL hold_ndone got %0d want 1", n_done); end
        tests_run++; if (done_c != 391) begin tests_failed++; $display("FAIL hold_done_cycle got %0d want 391", done_c); end
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL hold_busy_end got %b want 0", o_busy); end
        build_exp(32'h0000_0040);
        drive_frame(32'h0000_0040, 1'b0, 1'b0, stalls, done_at, n_wr, wr_full);
        d = first_diff();
        tests_run++; if (d != -1) begin tests_failed++; $display("FAIL restart_bytes first diff at %0d", d); end
    endtask

    task automatic test_reset_mid();
        int n_wr, stalls, done_at, wr_full, d;
        n_wr = 0;
        @(negedge clk);
        i_pc = 32'h0000_0040;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        for (int c = 0; c < 400 && n_wr < 100; c++) begin
            @(negedge clk);
            if (o_wr) n_wr++;
        end
        tests_run++; if (n_wr != 100) begin tests_failed++; $display("FAIL rst_reach_byte100 got %0d want 100", n_wr); end
        #1;
        i_reset = 1'b0;
        #1;
        tests_run++;
        if (o_wr !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            tests_failed++; $display("FAIL rst_async wr %b busy %b done %b want 0 0 0", o_wr, o_busy, o_done);
        end
        repeat (2) @(negedge clk);
        i_reset = 1'b1;
        n_wr = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (o_wr || o_busy) n_wr++;
        end
        tests_run++; if (n_wr != 0) begin tests_failed++; $display("FAIL rst_no_resume got %0d active cycles want 0", n_wr); end
        build_exp(32'h0000_0040);
        drive_frame(32'h0000_0040, 1'b0, 1'b0, stalls, done_at, n_wr, wr_full);
        d = first_diff();
        tests_run++; if (d != -1) begin tests_failed++; $display("FAIL rst_next_frame first diff at %0d", d); end
        tests_run++; if (done_at != 391) begin tests_failed++; $display("FAIL rst_next_done got %0d want 391", done_at); end
    endtask

    task automatic test_pc_jitter();
        int stalls, done_at, n_wr, wr_full, d;
        build_exp(32'h1234_5678);
        drive_frame(32'h1234_5678, 1'b0, 1'b1, stalls, done_at, n_wr, wr_full);
        tests_run++;
        if (got.size() < 5 || {got[4], got[3], got[2], got[1]} !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL pc_snapshot got %h want 12345678",
                     (got.size() >= 5) ? {got[4], got[3], got[2], got[1]} : 32'hxxxx_xxxx);
        end
        d = first_diff();
        tests_run++; if (d != -1) begin tests_failed++; $display("FAIL pc_frame first diff at %0d", d); end
        tests_run++;
        if (got.size() != 262 || got[261] !== 8'h08) begin
            tests_failed++; $display("FAIL pc_checksum got %h want 08", (got.size() == 262) ? got[261] : 8'hxx);
        end
    endtask

    initial begin
        i_reset = 1'b0;
        i_start = 1'b0;
        i_fifo_full = 1'b0;
        i_pc = '0;
        test_reset();
        test_basic_frame();
        test_stall();
        test_start_hold();
        test_reset_mid();
        test_pc_jitter();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
